operand_pair_sequencer: RTL and testbench
=========================================

Name: operand_pair_sequencer

Overview:
- Stage directly downstream of the 8-lane operand matcher.
- Accepts one packed match word per block: dense activation indices, dense weight indices and pair count.
- Serialises the word into one (activation index, weight index) pair per cycle for the operand-fetch/MAC stage, with a last-pair marker.
- Provides a valid/ready handshake on both sides so the matcher output can be throttled by MAC back-pressure.

Parameters:
- BITMASK_LENGTH, 8, lanes per block; maximum pairs per match word.
- INDEX_BITWIDTH, 3, width of each dense index.
- BITWIDTH_COUNT, 4, width of the pair-count field.
- RESULT_WIDTH, 64, width of the packed match word.

Ports:
- clock  in  1  single clock.
- resetn  in  1  asynchronous, active-low reset.
- ivalid  in  1  match word valid from upstream.
- oready  out  1  this block can accept a match word.
- matchResult  in  RESULT_WIDTH  packed word: [23:0] activation indices (index k at [3k+2:3k]); [47:24] weight indices; [51:48] pair count; [63:52] ignored.
- ovalid  out  1  pair valid to downstream.
- iready  in  1  downstream accepts pair.
- idxA  out  INDEX_BITWIDTH  activation index of current pair.
- idxW  out  INDEX_BITWIDTH  weight index of current pair.
- olast  out  1  current beat is the final beat of the block.
- oempty  out  1  block had zero pairs; beat carries no operands.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE; ovalid=0, olast=0, oempty=0, idxA=0, idxW=0.
  - Pointer and captured word cleared.
  - oready=1 one cycle after resetn deasserts; oready=0 while resetn=0.
  - Reset mid-block discards the remaining pairs; no partial beat follows reset.
- Input transfer: ivalid & oready at a rising edge.
- Output transfer: ovalid & iready at a rising edge.
- oready = (state==IDLE) | (ovalid & olast & iready). This is a combinational path from iready and allows back-to-back blocks with no bubble.
- States:
  - IDLE: ovalid=0. On input transfer: capture the word, ptr=0, go to ISSUE.
  - ISSUE: ovalid=1. Outputs are driven from registers:
    - idxA = capturedA[ptr]; idxW = capturedW[ptr].
    - olast = (ptr == cnt-1) | (cnt==0).
  - ISSUE, output transfer with olast=0: ptr increments.
  - ISSUE, output transfer with olast=1 and input transfer in the same cycle: capture the new word, ptr=0, stay in ISSUE.
  - ISSUE, output transfer with olast=1 and no input transfer: go to IDLE.
  - ISSUE, no output transfer: all outputs held stable (AXI-style: no change while ovalid & !iready).
- Latency: first pair is visible the cycle after the input transfer. Throughput: 1 pair/cycle, one cycle per empty block.
- cnt==0: emit exactly one beat with oempty=1, olast=1, idxA=idxW=0, so downstream still observes the block boundary.
- cnt > BITMASK_LENGTH (malformed): cnt is clamped to BITMASK_LENGTH at capture.
- ptr width is BITWIDTH_COUNT. ptr never exceeds cnt-1, so there is no wrap-around.
- ivalid while oready=0: ignored. Upstream must hold the word.

Optional Feature:
- Macro: OPERAND_PAIR_SEQ_PERF_CNT_EN.
- Defined: adds output ports pairCount (32 bits) and blockCount (32 bits).
  - pairCount increments on each output transfer with oempty=0.
  - blockCount increments on each output transfer with olast=1.
  - Both are cleared by resetn and wrap modulo 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Word with cnt=3, A indices {0,2,5}, W indices {1,1,3}, iready=1 -> beats (0,1),(2,1),(5,3) on 3 consecutive cycles; olast only on the third; oempty=0.
- cnt=0 word -> single beat with oempty=1, olast=1, idxA=idxW=0; then IDLE with oready=1.
- cnt=8, A={0..7}, W={7..0}, iready toggling 1,0,1,0 -> 8 beats in order; outputs held during iready=0; total 15 cycles from first ovalid.
- Two cnt=2 words, ivalid held high, iready=1 -> 4 consecutive beats with no bubble; oready pulses high on each olast cycle.
- resetn asserted after the second beat of a cnt=5 block -> ovalid drops immediately; after release, oready=1 and the next word starts at ptr=0.
- cnt field=12 -> exactly 8 beats emitted, last with olast=1; with OPERAND_PAIR_SEQ_PERF_CNT_EN defined, pairCount=8 and blockCount=1 afterwards.

Source files
------------

// File: rtl/operand_pair_sequencer.sv
// operand_pair_sequencer: serialises a packed match word into one (activation, weight) index pair per beat.
// Define OPERAND_PAIR_SEQ_PERF_CNT_EN to add the pairCount/blockCount performance counters.
module operand_pair_sequencer #(
  parameter int BITMASK_LENGTH = 8,
  parameter int INDEX_BITWIDTH = 3,
  parameter int BITWIDTH_COUNT = 4,
  parameter int RESULT_WIDTH   = 64
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      ivalid,
  output logic                      oready,
  input  logic [RESULT_WIDTH-1:0]   matchResult,
  output logic                      ovalid,
  input  logic                      iready,
  output logic [INDEX_BITWIDTH-1:0] idxA,
  output logic [INDEX_BITWIDTH-1:0] idxW,
  output logic                      olast,
  output logic                      oempty
`ifdef OPERAND_PAIR_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]               pairCount,
  output logic [31:0]               blockCount
`endif
);
  localparam int FW = BITMASK_LENGTH * INDEX_BITWIDTH;
  localparam int CL = 2 * FW;
  localparam int BW = $clog2(FW);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state_q, state_d;
  logic live_q;
  logic [FW-1:0] a_q, a_d, w_q, w_d;
  logic [BITWIDTH_COUNT-1:0] cnt_q, cnt_d, ptr_q, ptr_d, cnt_raw, cnt_in;
  logic [INDEX_BITWIDTH-1:0] idx_a_q, idx_a_d, idx_w_q, idx_w_d;
  logic ovalid_q, ovalid_d, olast_q, olast_d, oempty_q, oempty_d;
  logic [BW-1:0] base;
  logic in_xfer, out_xfer, unused_bits;
  assign unused_bits = ^matchResult[RESULT_WIDTH-1:CL+BITWIDTH_COUNT];
  assign cnt_raw = matchResult[CL +: BITWIDTH_COUNT];
  assign cnt_in = (cnt_raw > BITWIDTH_COUNT'(BITMASK_LENGTH)) ? BITWIDTH_COUNT'(BITMASK_LENGTH) : cnt_raw;
  // live_q keeps oready low until the first edge after reset release
  assign oready = live_q & ((state_q == IDLE) | (ovalid_q & olast_q & iready));
  assign in_xfer = ivalid & oready;
  assign out_xfer = ovalid_q & iready;
  assign ovalid = ovalid_q;
  assign olast = olast_q;
  assign oempty = oempty_q;
  assign idxA = idx_a_q;
  assign idxW = idx_w_q;
  always_comb begin
    state_d = in_xfer ? ISSUE : (out_xfer & olast_q) ? IDLE : state_q;
    a_d = in_xfer ? matchResult[FW-1:0] : a_q;
    w_d = in_xfer ? matchResult[FW +: FW] : w_q;
    cnt_d = in_xfer ? cnt_in : cnt_q;
    ptr_d = in_xfer ? '0 : (out_xfer & !olast_q) ? ptr_q + BITWIDTH_COUNT'(1) : ptr_q;
    base = BW'(ptr_d) * BW'(INDEX_BITWIDTH);
    ovalid_d = state_d == ISSUE;
    oempty_d = ovalid_d & (cnt_d == '0);
    olast_d = ovalid_d & ((ptr_d == cnt_d - BITWIDTH_COUNT'(1)) | (cnt_d == '0));
    idx_a_d = (ovalid_d & !oempty_d) ? INDEX_BITWIDTH'(a_d >> base) : '0;
    idx_w_d = (ovalid_d & !oempty_d) ? INDEX_BITWIDTH'(w_d >> base) : '0;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      live_q <= 1'b0;
      a_q <= '0;
      w_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
      ovalid_q <= 1'b0;
      olast_q <= 1'b0;
      oempty_q <= 1'b0;
      idx_a_q <= '0;
      idx_w_q <= '0;
    end else begin
      state_q <= state_d;
      live_q <= 1'b1;
      a_q <= a_d;
      w_q <= w_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      ovalid_q <= ovalid_d;
      olast_q <= olast_d;
      oempty_q <= oempty_d;
      idx_a_q <= idx_a_d;
      idx_w_q <= idx_w_d;
    end
  end
`ifdef OPERAND_PAIR_SEQ_PERF_CNT_EN
  logic [31:0] pair_count_q, pair_count_d, block_count_q, block_count_d;
  always_comb begin
    pair_count_d = pair_count_q + 32'(out_xfer & !oempty_q);
    block_count_d = block_count_q + 32'(out_xfer & olast_q);
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pair_count_q <= '0;
      block_count_q <= '0;
    end else begin
      pair_count_q <= pair_count_d;
      block_count_q <= block_count_d;
    end
  end
  assign pairCount = pair_count_q;
  assign blockCount = block_count_q;
`endif
endmodule

// File: tb/tb_operand_pair_sequencer.sv
// tb_operand_pair_sequencer: directed scenarios plus randomized traffic against a beat-queue model.
module tb_operand_pair_sequencer;
  logic clock = 0, resetn = 0, ivalid = 0, iready = 0;
  logic [63:0] matchResult = '0;
  logic oready, ovalid, olast, oempty;
  logic [2:0] idxA, idxW;
`ifdef OPERAND_PAIR_SEQ_PERF_CNT_EN
  logic [31:0] pairCount, blockCount;
`endif
  int tests = 0, fails = 0, pairs_m = 0, blocks_m = 0;
  typedef struct packed {logic [2:0] a; logic [2:0] w; logic last; logic empty;} beat_t;
  always #5 clock = ~clock;
  operand_pair_sequencer dut (
    .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready), .matchResult(matchResult),
    .ovalid(ovalid), .iready(iready), .idxA(idxA), .idxW(idxW), .olast(olast), .oempty(oempty)
`ifdef OPERAND_PAIR_SEQ_PERF_CNT_EN
    , .pairCount(pairCount), .blockCount(blockCount)
`endif
  );
  function automatic logic [63:0] mk(input logic [3:0] cnt, input logic [23:0] w, input logic [23:0] a);
    return {12'hA5C, cnt, w, a};
  endfunction
  task automatic test_reset();
    resetn = 0; ivalid = 0; iready = 0;
    repeat (3) @(negedge clock);
    tests++;
    if ({ovalid, olast, oempty, idxA, idxW, oready} !== 10'b0) begin
      fails++; $display("FAIL reset_outputs got %b exp %b", {ovalid, olast, oempty, idxA, idxW, oready}, 10'b0);
    end
    resetn = 1; #1;
    tests++;
    if (oready !== 1'b0) begin fails++; $display("FAIL reset_release_oready got %b exp 0", oready); end
    @(negedge clock);
    tests++;
    if (oready !== 1'b1) begin fails++; $display("FAIL reset_oready_after got %b exp 1", oready); end
  endtask
  task automatic test_basic();
    logic [8:0] e [3] = '{9'b1_000_001_0_0, 9'b1_010_001_0_0, 9'b1_101_011_1_0};
    @(negedge clock);
    ivalid = 1; iready = 1; matchResult = mk(4'd3, 24'o311, 24'o520);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      ivalid = 0;
      tests++;
      if ({ovalid, idxA, idxW, olast, oempty} !== e[i]) begin
        fails++; $display("FAIL basic_beat%0d got %b exp %b", i, {ovalid, idxA, idxW, olast, oempty}, e[i]);
      end
    end
    @(negedge clock);
    tests++;
    if ({ovalid, oready} !== 2'b01) begin fails++; $display("FAIL basic_idle got %b exp 01", {ovalid, oready}); end
  endtask
  task automatic test_empty();
    ivalid = 1; iready = 1; matchResult = mk(4'd0, 24'o77777777, 24'o77777777);
    @(negedge clock);
    ivalid = 0;
    tests++;
    if ({ovalid, idxA, idxW, olast, oempty} !== 9'b1_000_000_1_1) begin
      fails++; $display("FAIL empty_beat got %b exp %b", {ovalid, idxA, idxW, olast, oempty}, 9'b1_000_000_1_1);
    end
    @(negedge clock);
    tests++;
    if ({ovalid, oready} !== 2'b01) begin fails++; $display("FAIL empty_idle got %b exp 01", {ovalid, oready}); end
  endtask
  task automatic test_backpressure();
    logic [8:0] e;
    int k;
    ivalid = 1; iready = 0; matchResult = mk(4'd8, 24'o01234567, 24'o76543210);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      ivalid = 0;
      k = (i + 1) / 2;
      e = {1'b1, 3'(k), 3'(7 - k), k == 7, 1'b0};
      tests++;
      if (i == 15 && ovalid !== 1'b0) begin
        fails++; $display("FAIL bp_end_ovalid got %b exp 0", ovalid);
      end else if (i < 15 && {ovalid, idxA, idxW, olast, oempty} !== e) begin
        fails++; $display("FAIL bp_cycle%0d got %b exp %b", i, {ovalid, idxA, idxW, olast, oempty}, e);
      end
      iready = (i % 2 == 0);
    end
  endtask
  task automatic test_back_to_back();
    logic [9:0] e [4] = '{10'b1_001_011_0_0_0, 10'b1_010_100_1_0_1, 10'b1_101_111_0_0_0, 10'b1_110_000_1_0_1};
    iready = 1; ivalid = 1; matchResult = mk(4'd2, 24'o43, 24'o21);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 0) matchResult = mk(4'd2, 24'o07, 24'o65);
      if (i == 2) ivalid = 0;
      #1;
      tests++;
      if ({ovalid, idxA, idxW, olast, oempty, oready} !== e[i]) begin
        fails++; $display("FAIL b2b_cycle%0d got %b exp %b", i, {ovalid, idxA, idxW, olast, oempty, oready}, e[i]);
      end
    end
    @(negedge clock);
    tests++;
    if (ovalid !== 1'b0) begin fails++; $display("FAIL b2b_end_ovalid got %b exp 0", ovalid); end
  endtask
  task automatic test_reset_mid();
    iready = 1; ivalid = 1; matchResult = mk(4'd5, 24'o12345, 24'o43210);
    repeat (3) begin @(negedge clock); ivalid = 0; end
    tests++;
    if ({ovalid, idxA, idxW} !== 7'b1_010_011) begin
      fails++; $display("FAIL rstmid_beat2 got %b exp %b", {ovalid, idxA, idxW}, 7'b1_010_011);
    end
    resetn = 0; #1;
    tests++;
    if ({ovalid, olast, oempty, oready} !== 4'b0) begin
      fails++; $display("FAIL rstmid_async got %b exp 0000", {ovalid, olast, oempty, oready});
    end
    @(negedge clock); resetn = 1;
    @(negedge clock);
    tests++;
    if ({ovalid, oready} !== 2'b01) begin fails++; $display("FAIL rstmid_release got %b exp 01", {ovalid, oready}); end
    ivalid = 1; matchResult = mk(4'd2, 24'o12, 24'o67);
    @(negedge clock);
    ivalid = 0;
    tests++;
    if ({ovalid, idxA, idxW, olast, oempty} !== 9'b1_111_010_0_0) begin
      fails++; $display("FAIL rstmid_next0 got %b exp %b", {ovalid, idxA, idxW, olast, oempty}, 9'b1_111_010_0_0);
    end
    @(negedge clock);
    tests++;
    if ({ovalid, idxA, idxW, olast, oempty} !== 9'b1_110_001_1_0) begin
      fails++; $display("FAIL rstmid_next1 got %b exp %b", {ovalid, idxA, idxW, olast, oempty}, 9'b1_110_001_1_0);
    end
    @(negedge clock);
  endtask
  task automatic test_clamp();
    int n = 0;
    resetn = 0; ivalid = 0;
    @(negedge clock); resetn = 1;
    @(negedge clock);
    iready = 1; ivalid = 1; matchResult = mk(4'd12, 24'o01234567, 24'o76543210);
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      ivalid = 0;
      if (ovalid) begin
        tests++;
        if ({idxA, idxW, olast} !== {3'(n), 3'(7 - n), n == 7}) begin
          fails++; $display("FAIL clamp_beat%0d got %b exp %b", n, {idxA, idxW, olast}, {3'(n), 3'(7 - n), n == 7});
        end
        n++;
      end
    end
    tests++;
    if (n != 8) begin fails++; $display("FAIL clamp_count got %0d exp 8", n); end
`ifdef OPERAND_PAIR_SEQ_PERF_CNT_EN
    tests++;
    if ({pairCount, blockCount} !== {32'd8, 32'd1}) begin
      fails++; $display("FAIL clamp_perf got %0d/%0d exp 8/1", pairCount, blockCount);
    end
`endif
    pairs_m = 8; blocks_m = 1;
  endtask
  task automatic test_random();
    beat_t q[$];
    beat_t e;
    logic [63:0] word;
    logic acc = 0, exp_rdy;
    int n;
    ivalid = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      tests++;
      if (ovalid !== (q.size() != 0)) begin
        fails++; $display("FAIL rand_ovalid cycle %0d got %b exp %b", c, ovalid, q.size() != 0);
      end else if (ovalid && {idxA, idxW, olast, oempty} !== q[0]) begin
        fails++; $display("FAIL rand_beat cycle %0d got %b exp %b", c, {idxA, idxW, olast, oempty}, q[0]);
      end
`ifdef OPERAND_PAIR_SEQ_PERF_CNT_EN
      tests++;
      if ({pairCount, blockCount} !== {32'(pairs_m), 32'(blocks_m)}) begin
        fails++; $display("FAIL rand_perf cycle %0d got %0d/%0d exp %0d/%0d", c, pairCount, blockCount, pairs_m, blocks_m);
      end
`endif
      if (acc) ivalid = 0;
      if (!ivalid && $urandom_range(0, 2) == 0) begin ivalid = 1; matchResult = {$urandom, $urandom}; end
      iready = $urandom_range(0, 3) != 0;
      #1;
      exp_rdy = (q.size() == 0) || (q[0].last && iready);
      tests++;
      if (oready !== exp_rdy) begin fails++; $display("FAIL rand_oready cycle %0d got %b exp %b", c, oready, exp_rdy); end
      acc = ivalid && oready;
      if (ovalid && iready && q.size() != 0) begin
        e = q.pop_front();
        if (!e.empty) pairs_m++;
        if (e.last) blocks_m++;
      end
      if (acc) begin
        word = matchResult;
        n = (word[51:48] > 4'd8) ? 8 : int'(word[51:48]);
        if (n == 0) q.push_back(8'b000_000_1_1);
        for (int k = 0; k < n; k++) q.push_back({word[3*k +: 3], word[24 + 3*k +: 3], k == n - 1, 1'b0});
      end
    end
    ivalid = 0; iready = 0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_clamp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
